// File: rtl/avalon_input_pio_irq_pkg.sv
// Shared constants and helpers for the Avalon-MM input PIO with interrupt.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pio_pkg;

    // Avalon data bus width seen by the Nios II slave port
    localparam int PIO_BUS_W = 32;

    // Register map, word addresses
    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_RSVD = 2'd1;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

    // Edge selection for edge_capture
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // Post-reset priming sequence: three clocks with edge detection disabled
    typedef enum logic [1:0] {
        PRIME_0    = 2'd0,
        PRIME_1    = 2'd1,
        PRIME_2    = 2'd2,
        PRIME_DONE = 2'd3
    } prime_state_e;

    // Avalon write qualifier: chipselect with the active-low write strobe
    function automatic logic pio_bus_we(input logic chipselect, input logic write_n);
        return chipselect & ~write_n;
    endfunction

endpackage

// File: rtl/avalon_input_pio_irq_if.sv
// Avalon-MM slave bus bundle for the input PIO (address/strobe/data).
// Latency: readdata is registered by the slave, one clock after address.
// Backpressure: none; the slave never stalls (no waitrequest).
interface avalon_input_pio_irq_if;
    import pio_pkg::*;

    logic [1:0]           address;
    logic                 chipselect;
    logic                 write_n;
    logic [PIO_BUS_W-1:0] writedata;
    logic [PIO_BUS_W-1:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/avalon_input_pio_irq_debounce.sv
// Single-bit debouncer: filtered follows sample after it has differed for N clocks.
// Latency: DEBOUNCE_CYCLES clocks from the first differing sample to filtered update.
// Backpressure: none; free-running every clock.
module pio_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sample,
    output logic filtered
);

    // A counter of 1 bit still works for a one-clock filter; otherwise size to N-1
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // Count consecutive clocks where the sample disagrees with the filtered value;
    // any agreement restarts the count, so glitches shorter than N never pass.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            filtered <= 1'b0;
        end else if (sample == filtered) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            filtered <= sample;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/avalon_input_pio_irq.sv
// Avalon-MM input PIO: synchronise, debounce, capture edges, raise maskable level IRQ.
// Latency: in_port to readdata 3 clks (+DEBOUNCE_CYCLES); edge to irq 4 clks; reads 1 clk.
// Backpressure: none; every Avalon access completes in one cycle, irq is a level.
module avalon_input_pio_irq
    import pio_pkg::*;
#(
    parameter int               WIDTH           = 8,
    parameter int               EDGE_TYPE       = EDGE_RISING,
    parameter int               DEBOUNCE_CYCLES = 0,
    parameter logic [WIDTH-1:0] IRQ_RESET_MASK  = '0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    avalon_input_pio_irq_if.slave  bus,
    input  logic [WIDTH-1:0]       in_port,
    output logic                   irq
);

    logic [WIDTH-1:0]     sync_s1;
    logic [WIDTH-1:0]     sync_s2;
    logic [WIDTH-1:0]     filtered;
    logic [WIDTH-1:0]     prev;
    logic [WIDTH-1:0]     edge_vec;
    logic [WIDTH-1:0]     edge_clr;
    logic [WIDTH-1:0]     edge_capture;
    logic [WIDTH-1:0]     irq_mask;
    logic [PIO_BUS_W-1:0] rd_mux;
    logic                 bus_we;
    logic                 edge_en;
    prime_state_e         prime_q;
    prime_state_e         prime_d;

    // Write data above WIDTH is a don't-care; fold it into a sink
    logic unused_wdata;
    assign unused_wdata = ^bus.writedata;

    // Two-flop synchroniser on the asynchronous pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
        end else begin
            sync_s1 <= in_port;
            sync_s2 <= sync_s1;
        end
    end

    // Optional per-bit debounce; with zero cycles the synchroniser output is used directly
    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign filtered = sync_s2;
        end else begin : g_debounce
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                pio_debounce_bit #(
                    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
                ) u_db (
                    .clk     (clk),
                    .reset_n (reset_n),
                    .sample  (sync_s2[i]),
                    .filtered(filtered[i])
                );
            end
        end
    endgenerate

    // Priming state register: restarts on every reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prime_q <= PRIME_0;
        end else begin
            prime_q <= prime_d;
        end
    end

    // Priming sequence: hold edge detection off for three clocks so an input
    // held high through reset does not look like a fresh edge
    always_comb begin
        prime_d = prime_q;
        edge_en = 1'b0;
        unique case (prime_q)
            PRIME_0:    prime_d = PRIME_1;
            PRIME_1:    prime_d = PRIME_2;
            PRIME_2:    prime_d = PRIME_DONE;
            PRIME_DONE: edge_en = 1'b1;
            default:    prime_d = PRIME_0;
        endcase
    end

    // Previous filtered value for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= '0;
        end else begin
            prev <= filtered;
        end
    end

    // Edge selection fixed at elaboration
    always_comb begin
        edge_vec = '0;
        if (EDGE_TYPE == EDGE_RISING) begin
            edge_vec = filtered & ~prev;
        end else if (EDGE_TYPE == EDGE_FALLING) begin
            edge_vec = ~filtered & prev;
        end else begin
            edge_vec = filtered ^ prev;
        end
    end

    assign bus_we = pio_bus_we(bus.chipselect, bus.write_n);

    // Write-one-to-clear mask for edge_capture
    always_comb begin
        edge_clr = '0;
        if (bus_we && (bus.address == PIO_ADDR_EDGE)) begin
            edge_clr = bus.writedata[WIDTH-1:0];
        end
    end

    // Sticky edge capture; a new edge wins over a clear landing on the same clock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
        end else begin
            edge_capture <= (edge_capture & ~edge_clr) | (edge_vec & {WIDTH{edge_en}});
        end
    end

    // Interrupt mask register; data and reserved addresses ignore writes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= IRQ_RESET_MASK;
        end else if (bus_we && (bus.address == PIO_ADDR_MASK)) begin
            irq_mask <= bus.writedata[WIDTH-1:0];
        end
    end

    // Registered level interrupt from any unmasked captured edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(edge_capture & irq_mask);
        end
    end

    // Read mux, zero-extended to the bus width
    always_comb begin
        rd_mux = '0;
        unique case (bus.address)
            PIO_ADDR_DATA: rd_mux[WIDTH-1:0] = filtered;
            PIO_ADDR_RSVD: rd_mux = '0;
            PIO_ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask;
            PIO_ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_capture;
            default:       rd_mux = '0;
        endcase
    end

    // Readdata registered every clock, no read strobe needed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_avalon_input_pio_irq.sv
// Bench for the input PIO: directed scenarios plus randomized traffic vs a behavioural model.
// Two instances: rising-edge bypass, and any-edge with 4-clock debounce and nonzero reset mask.
// Outputs are sampled on the falling clock edge; inputs are driven there too.
module tb_avalon_input_pio_irq;
    import pio_pkg::*;

    localparam int               ET_CFG [2] = '{EDGE_RISING, EDGE_ANY};
    localparam int               DB_CFG [2] = '{0, 4};
    localparam logic [7:0]       RM_CFG [2] = '{8'h00, 8'h3C};

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] inp [2];
    logic       irq_r;
    logic       irq_d;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    avalon_input_pio_irq_if bus_r ();
    avalon_input_pio_irq_if bus_d ();

    avalon_input_pio_irq #(
        .WIDTH(8), .EDGE_TYPE(EDGE_RISING), .DEBOUNCE_CYCLES(0), .IRQ_RESET_MASK(8'h00)
    ) dut_r (
        .clk(clk), .reset_n(reset_n), .bus(bus_r), .in_port(inp[0]), .irq(irq_r)
    );

    avalon_input_pio_irq #(
        .WIDTH(8), .EDGE_TYPE(EDGE_ANY), .DEBOUNCE_CYCLES(4), .IRQ_RESET_MASK(8'h3C)
    ) dut_d (
        .clk(clk), .reset_n(reset_n), .bus(bus_d), .in_port(inp[1]), .irq(irq_d)
    );

    // ---------------- behavioural reference model ----------------
    logic [7:0]  m_s1 [2];
    logic [7:0]  m_s2 [2];
    logic [7:0]  m_f [2];
    logic [7:0]  m_prev [2];
    logic [7:0]  m_ec [2];
    logic [7:0]  m_mask [2];
    logic        m_irq [2];
    logic [31:0] m_rd [2];
    int          m_run [2][8];
    int          m_clks [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_s1[k] = 0; m_s2[k] = 0; m_f[k] = 0; m_prev[k] = 0; m_ec[k] = 0;
            m_mask[k] = RM_CFG[k]; m_irq[k] = 0; m_rd[k] = 0; m_clks[k] = 0;
            for (int b = 0; b < 8; b++) m_run[k][b] = 0;
        end
    endtask

    // One clock of the register-level behaviour, from values before the edge
    task automatic model_step(input int k, input logic [7:0] in_v, input logic cs,
                              input logic wn, input logic [1:0] addr, input logic [31:0] wd);
        logic [7:0] f_now, edg, clr;
        logic       wr;
        f_now = (DB_CFG[k] == 0) ? m_s2[k] : m_f[k];
        if (ET_CFG[k] == EDGE_RISING)       edg = f_now & ~m_prev[k];
        else if (ET_CFG[k] == EDGE_FALLING) edg = ~f_now & m_prev[k];
        else                                edg = f_now ^ m_prev[k];
        wr  = cs && !wn;
        clr = (wr && addr == 2'd3) ? wd[7:0] : 8'h00;
        case (addr)
            2'd0:    m_rd[k] = {24'h0, f_now};
            2'd2:    m_rd[k] = {24'h0, m_mask[k]};
            2'd3:    m_rd[k] = {24'h0, m_ec[k]};
            default: m_rd[k] = 32'h0;
        endcase
        m_irq[k] = |(m_ec[k] & m_mask[k]);
        m_ec[k]  = (m_ec[k] & ~clr) | ((m_clks[k] >= 3) ? edg : 8'h00);
        if (wr && addr == 2'd2) m_mask[k] = wd[7:0];
        if (DB_CFG[k] != 0) begin
            for (int b = 0; b < 8; b++) begin
                if (m_s2[k][b] != m_f[k][b]) begin
                    m_run[k][b]++;
                    if (m_run[k][b] == DB_CFG[k]) begin
                        m_f[k][b]   = m_s2[k][b];
                        m_run[k][b] = 0;
                    end
                end else begin
                    m_run[k][b] = 0;
                end
            end
        end
        m_prev[k] = f_now;
        m_s2[k]   = m_s1[k];
        m_s1[k]   = in_v;
        if (m_clks[k] < 100) m_clks[k]++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                model_reset();
            end else begin
                model_step(0, inp[0], bus_r.chipselect, bus_r.write_n, bus_r.address, bus_r.writedata);
                model_step(1, inp[1], bus_d.chipselect, bus_d.write_n, bus_d.address, bus_d.writedata);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic bus_drive(input int k, input logic cs, input logic wn,
                             input logic [1:0] a, input logic [31:0] d);
        if (k == 0) begin
            bus_r.chipselect = cs; bus_r.write_n = wn; bus_r.address = a; bus_r.writedata = d;
        end else begin
            bus_d.chipselect = cs; bus_d.write_n = wn; bus_d.address = a; bus_d.writedata = d;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        inp[0] = 8'hA5;
        inp[1] = 8'h00;
        bus_drive(0, 1'b0, 1'b1, 2'd0, 32'h0);
        bus_drive(1, 1'b0, 1'b1, 2'd0, 32'h0);
        repeat (3) @(negedge clk);
        n_checks++; if (bus_r.readdata !== 32'h0) begin n_fail++; $display("FAIL reset_rd_r: got %h expected %h", bus_r.readdata, 32'h0); end
        n_checks++; if (irq_r !== 1'b0) begin n_fail++; $display("FAIL reset_irq_r: got %b expected 0", irq_r); end
        n_checks++; if (bus_d.readdata !== 32'h0) begin n_fail++; $display("FAIL reset_rd_d: got %h expected %h", bus_d.readdata, 32'h0); end
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if (bus_r.readdata !== 32'h0) begin n_fail++; $display("FAIL data_e0: got %h expected %h", bus_r.readdata, 32'h0); end
        @(negedge clk);
        n_checks++; if (bus_r.readdata !== 32'h0) begin n_fail++; $display("FAIL data_e1: got %h expected %h", bus_r.readdata, 32'h0); end
        @(negedge clk);
        n_checks++; if (bus_r.readdata !== 32'h000000A5) begin n_fail++; $display("FAIL data_e2: got %h expected %h", bus_r.readdata, 32'hA5); end
        bus_drive(0, 1'b0, 1'b1, 2'd3, 32'h0);
        bus_drive(1, 1'b0, 1'b1, 2'd2, 32'h0);
        repeat (4) @(negedge clk);
        n_checks++; if (bus_r.readdata !== 32'h0) begin n_fail++; $display("FAIL prime_ec: got %h expected %h", bus_r.readdata, 32'h0); end
        n_checks++; if (irq_r !== 1'b0) begin n_fail++; $display("FAIL prime_irq: got %b expected 0", irq_r); end
        n_checks++; if (bus_d.readdata !== 32'h3C) begin n_fail++; $display("FAIL mask_reset_d: got %h expected %h", bus_d.readdata, 32'h3C); end
    endtask

    task automatic test_rising();
        inp[0] = 8'hA4;
        bus_drive(0, 1'b1, 1'b0, 2'd2, 32'h1);
        @(negedge clk);
        bus_drive(0, 1'b0, 1'b1, 2'd3, 32'h0);
        repeat (4) @(negedge clk);
        n_checks++; if (bus_r.readdata !== 32'h0) begin n_fail++; $display("FAIL fall_ignored: got %h expected %h", bus_r.readdata, 32'h0); end
        inp[0] = 8'hA5;
        repeat (3) @(negedge clk);
        n_checks++; if (irq_r !== 1'b0) begin n_fail++; $display("FAIL irq_early: got %b expected 0", irq_r); end
        @(negedge clk);
        n_checks++; if (bus_r.readdata !== 32'h1) begin n_fail++; $display("FAIL rise_ec: got %h expected %h", bus_r.readdata, 32'h1); end
        n_checks++; if (irq_r !== 1'b1) begin n_fail++; $display("FAIL rise_irq: got %b expected 1", irq_r); end
        bus_drive(0, 1'b1, 1'b0, 2'd3, 32'h1);
        @(negedge clk);
        bus_drive(0, 1'b0, 1'b1, 2'd3, 32'h0);
        @(negedge clk);
        n_checks++; if (bus_r.readdata !== 32'h0) begin n_fail++; $display("FAIL w1c_ec: got %h expected %h", bus_r.readdata, 32'h0); end
        n_checks++; if (irq_r !== 1'b0) begin n_fail++; $display("FAIL w1c_irq: got %b expected 0", irq_r); end
    endtask

    task automatic test_collision();
        inp[0] = 8'hA4;
        repeat (4) @(negedge clk);
        inp[0] = 8'hA5;
        repeat (2) @(negedge clk);
        bus_drive(0, 1'b1, 1'b0, 2'd3, 32'h1);
        @(negedge clk);
        bus_drive(0, 1'b0, 1'b1, 2'd3, 32'h0);
        @(negedge clk);
        n_checks++; if (bus_r.readdata !== 32'h1) begin n_fail++; $display("FAIL collide_ec: got %h expected %h", bus_r.readdata, 32'h1); end
        @(negedge clk);
        n_checks++; if (irq_r !== 1'b1) begin n_fail++; $display("FAIL collide_irq: got %b expected 1", irq_r); end
        bus_drive(0, 1'b1, 1'b0, 2'd3, 32'hFF);
        @(negedge clk);
        bus_drive(0, 1'b0, 1'b1, 2'd3, 32'h0);
        repeat (2) @(negedge clk);
        n_checks++; if (bus_r.readdata !== 32'h0) begin n_fail++; $display("FAIL collide_clean: got %h expected %h", bus_r.readdata, 32'h0); end
    endtask

    task automatic test_debounce();
        logic [31:0] exp;
        bus_drive(1, 1'b0, 1'b1, 2'd0, 32'h0);
        inp[1] = 8'h04;
        repeat (3) @(negedge clk);
        inp[1] = 8'h00;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++; if (bus_d.readdata !== 32'h0) begin n_fail++; $display("FAIL glitch_data c%0d: got %h expected %h", c, bus_d.readdata, 32'h0); end
        end
        bus_drive(1, 1'b0, 1'b1, 2'd3, 32'h0);
        repeat (2) @(negedge clk);
        n_checks++; if (bus_d.readdata !== 32'h0) begin n_fail++; $display("FAIL glitch_ec: got %h expected %h", bus_d.readdata, 32'h0); end
        bus_drive(1, 1'b0, 1'b1, 2'd0, 32'h0);
        @(negedge clk);
        inp[1] = 8'h04;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            exp = (c >= 7 && c <= 12) ? 32'h4 : 32'h0;
            n_checks++; if (bus_d.readdata !== exp) begin n_fail++; $display("FAIL pulse_data c%0d: got %h expected %h", c, bus_d.readdata, exp); end
            if (c == 6) inp[1] = 8'h00;
        end
        bus_drive(1, 1'b0, 1'b1, 2'd3, 32'h0);
        repeat (2) @(negedge clk);
        n_checks++; if (bus_d.readdata !== 32'h4) begin n_fail++; $display("FAIL pulse_ec: got %h expected %h", bus_d.readdata, 32'h4); end
        n_checks++; if (irq_d !== 1'b1) begin n_fail++; $display("FAIL pulse_irq: got %b expected 1", irq_d); end
        bus_drive(1, 1'b1, 1'b0, 2'd3, 32'h4);
        @(negedge clk);
        bus_drive(1, 1'b0, 1'b1, 2'd3, 32'h0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_any_edge();
        bus_drive(1, 1'b1, 1'b0, 2'd2, 32'hFF);
        inp[1] = 8'h80;
        @(negedge clk);
        bus_drive(1, 1'b0, 1'b1, 2'd3, 32'h0);
        repeat (12) @(negedge clk);
        bus_drive(1, 1'b1, 1'b0, 2'd3, 32'hFF);
        @(negedge clk);
        bus_drive(1, 1'b0, 1'b1, 2'd3, 32'h0);
        repeat (2) @(negedge clk);
        n_checks++; if (bus_d.readdata !== 32'h0) begin n_fail++; $display("FAIL any_cleared: got %h expected %h", bus_d.readdata, 32'h0); end
        inp[1] = 8'h00;
        repeat (12) @(negedge clk);
        n_checks++; if (bus_d.readdata !== 32'h80) begin n_fail++; $display("FAIL any_fall_ec: got %h expected %h", bus_d.readdata, 32'h80); end
        n_checks++; if (irq_d !== 1'b1) begin n_fail++; $display("FAIL any_fall_irq: got %b expected 1", irq_d); end
        bus_drive(1, 1'b1, 1'b0, 2'd2, 32'h0);
        @(negedge clk);
        bus_drive(1, 1'b0, 1'b1, 2'd3, 32'h0);
        @(negedge clk);
        n_checks++; if (irq_d !== 1'b0) begin n_fail++; $display("FAIL mask0_irq: got %b expected 0", irq_d); end
        n_checks++; if (bus_d.readdata !== 32'h80) begin n_fail++; $display("FAIL mask0_ec: got %h expected %h", bus_d.readdata, 32'h80); end
    endtask

    task automatic test_reset_mid();
        bus_drive(1, 1'b1, 1'b0, 2'd2, 32'hFF);
        @(negedge clk);
        bus_drive(1, 1'b0, 1'b1, 2'd3, 32'h0);
        repeat (2) @(negedge clk);
        n_checks++; if (irq_d !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq: got %b expected 1", irq_d); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (irq_d !== 1'b0) begin n_fail++; $display("FAIL async_irq: got %b expected 0", irq_d); end
        n_checks++; if (bus_d.readdata !== 32'h0) begin n_fail++; $display("FAIL async_rd: got %h expected %h", bus_d.readdata, 32'h0); end
        n_checks++; if (dut_d.edge_capture !== 8'h00) begin n_fail++; $display("FAIL async_ec: got %h expected %h", dut_d.edge_capture, 8'h00); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        bus_drive(0, 1'b0, 1'b1, 2'd2, 32'h0);
        bus_drive(1, 1'b0, 1'b1, 2'd2, 32'h0);
        repeat (2) @(negedge clk);
        n_checks++; if (bus_r.readdata !== 32'h0) begin n_fail++; $display("FAIL mask_back_r: got %h expected %h", bus_r.readdata, 32'h0); end
        n_checks++; if (bus_d.readdata !== 32'h3C) begin n_fail++; $display("FAIL mask_back_d: got %h expected %h", bus_d.readdata, 32'h3C); end
        bus_drive(0, 1'b0, 1'b1, 2'd3, 32'h0);
        repeat (6) @(negedge clk);
        n_checks++; if (bus_r.readdata !== 32'h0) begin n_fail++; $display("FAIL reprime_ec: got %h expected %h", bus_r.readdata, 32'h0); end
    endtask

    task automatic test_random();
        int hold [2];
        hold[0] = 0;
        hold[1] = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            n_checks++; if (bus_r.readdata !== m_rd[0]) begin n_fail++; $display("FAIL rand_rd_r c%0d: got %h expected %h", c, bus_r.readdata, m_rd[0]); end
            n_checks++; if (irq_r !== m_irq[0]) begin n_fail++; $display("FAIL rand_irq_r c%0d: got %b expected %b", c, irq_r, m_irq[0]); end
            n_checks++; if (bus_d.readdata !== m_rd[1]) begin n_fail++; $display("FAIL rand_rd_d c%0d: got %h expected %h", c, bus_d.readdata, m_rd[1]); end
            n_checks++; if (irq_d !== m_irq[1]) begin n_fail++; $display("FAIL rand_irq_d c%0d: got %b expected %b", c, irq_d, m_irq[1]); end
            for (int k = 0; k < 2; k++) begin
                if (hold[k] == 0) begin
                    inp[k]  = 8'($urandom);
                    hold[k] = $urandom_range(1, 8);
                end else begin
                    hold[k]--;
                end
                bus_drive(k, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                          2'($urandom_range(0, 3)), $urandom);
            end
        end
        bus_drive(0, 1'b0, 1'b1, 2'd0, 32'h0);
        bus_drive(1, 1'b0, 1'b1, 2'd0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_rising();
        test_collision();
        test_debounce();
        test_any_edge();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
